// File: rtl/pipeline_control.sv
// Pipeline hazard controller: sequences exception flushes, mispredict redirects,
// D-cache miss stalls and fence.i drains into lock/flush/PC-select controls.
module pipeline_control #(
  parameter int unsigned FLUSH_LEN = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             xcpt_commit_i,
  input  logic             branch_mispred_i,
  input  logic             dcache_miss_i,
  input  logic             dcache_ready_i,
  input  logic             fence_i_i,
  input  logic             store_buf_empty_i,
  input  logic             div_busy_i,
  output logic             lock_o,
  output logic             flush_p1_o,
  output logic             flush_p2_o,
  output logic [1:0]       pc_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {StRun, StMemWait, StFenceDrain, StXcptFlush} state_e;

  localparam logic [3:0] FlushInit = 4'(FLUSH_LEN - 1);

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             mispred_q, mispred_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             drain_done;
  logic             lock_raw;

  assign drain_done = store_buf_empty_i & ~div_busy_i;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    mispred_d   = 1'b0;
    if (xcpt_commit_i) begin
      state_d     = StXcptFlush;
      flush_cnt_d = FlushInit;
    end else begin
      unique case (state_q)
        StRun: begin
          if (branch_mispred_i) begin
            mispred_d = 1'b1;
          end else if (dcache_miss_i) begin
            state_d = StMemWait;
          end else if (fence_i_i) begin
            state_d = StFenceDrain;
          end
        end
        StMemWait: begin
          if (dcache_ready_i) state_d = StRun;
        end
        StFenceDrain: begin
          if (drain_done) state_d = StRun;
        end
        StXcptFlush: begin
          if (flush_cnt_q == 4'd0) begin
            state_d = StRun;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    lock_raw   = 1'b0;
    flush_p1_o = 1'b0;
    flush_p2_o = 1'b0;
    pc_sel_o   = 2'b00;
    unique case (state_q)
      StRun: begin
        lock_raw = div_busy_i;
        if (mispred_q) begin
          pc_sel_o   = 2'b01;
          // The mispredict flush yields to a divider lock in the same cycle.
          flush_p2_o = ~div_busy_i;
        end
      end
      StMemWait: lock_raw = 1'b1;
      StFenceDrain: begin
        if (drain_done) begin
          flush_p2_o = 1'b1;
          pc_sel_o   = 2'b11;
        end else begin
          lock_raw = 1'b1;
        end
      end
      StXcptFlush: begin
        flush_p1_o = 1'b1;
        pc_sel_o   = 2'b10;
      end
      default: lock_raw = 1'b0;
    endcase
  end

  // Reset gates lock so a busy divider cannot assert it while held in reset.
  assign lock_o = lock_raw & rst_ni;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (lock_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      flush_cnt_q <= 4'd0;
      mispred_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mispred_q   <= mispred_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
